md_sequencer: RTL and testbench

//  Multi-cycle multiply/divide unit: sequences MULT/MULTU/DIV/DIVU beside the EX-stage ALU and owns HI/LO.
//  - Sits in EX, in parallel with the ALU.
//  - Accepts one operation per start pulse and holds busy for a fixed latency.
//  - Commits HI/LO when the operation completes.
//  - Serves MTHI/MTLO/MFHI/MFLO.
//  - The hazard unit stalls D whenever an MD-class instruction is in D while (start | busy).

---
 rtl/md_sequencer_pkg.sv | 40 ++++
 rtl/md_sequencer.sv | 139 +++++++++++++
 tb/tb_md_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared multiply/divide definitions: md_op encoding, sequencer
// states, default latencies and counter sizing.
package md_sequencer_pkg;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Width needed to hold the larger of the two latencies.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    localparam int MD_CNT_W = cnt_width(MD_MULT_CYCLES, MD_DIV_CYCLES);

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE     = 2'd0,
        MD_BUSY_MUL = 2'd1,
        MD_BUSY_DIV = 2'd2
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_pair_t;

endpackage

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer beside the EX ALU; owns HI/LO
// and serves MTHI/MTLO/MFHI/MFLO.
import md_sequencer_pkg::*;

module md_sequencer #(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] In0,
    input  logic [31:0] In1,
    output logic        busy,
    output logic [31:0] Res,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    md_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    md_pair_t      r_pend;
    logic          r_pend_ok;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_is_mul;
    logic          w_is_div;
    logic          w_sgn_mul;
    logic          w_sgn_div;
    logic [63:0]   w_a_ext;
    logic [63:0]   w_b_ext;
    logic [63:0]   w_prod;
    logic [31:0]   w_a_abs;
    logic [31:0]   w_b_abs;
    logic [31:0]   w_den;
    logic [31:0]   w_uq;
    logic [31:0]   w_ur;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic          w_div_zero;

    assign w_is_mul  = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign w_is_div  = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign w_sgn_mul = (md_op == MD_MULT);
    assign w_sgn_div = (md_op == MD_DIV);

    // Sign-extending to 64 bits lets one unsigned multiply serve both forms.
    assign w_a_ext = {{32{w_sgn_mul & In0[31]}}, In0};
    assign w_b_ext = {{32{w_sgn_mul & In1[31]}}, In1};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed divide on magnitudes; this also yields 0x80000000 for MIN/-1.
    assign w_a_abs    = (w_sgn_div && In0[31]) ? (~In0 + 32'd1) : In0;
    assign w_b_abs    = (w_sgn_div && In1[31]) ? (~In1 + 32'd1) : In1;
    assign w_div_zero = (In1 == 32'd0);
    assign w_den      = w_div_zero ? 32'd1 : w_b_abs;
    assign w_uq       = w_a_abs / w_den;
    assign w_ur       = w_a_abs % w_den;
    assign w_q = (w_sgn_div && (In0[31] ^ In1[31])) ? (~w_uq + 32'd1) : w_uq;
    assign w_r = (w_sgn_div && In0[31]) ? (~w_ur + 32'd1) : w_ur;

    // Sequencer FSM: launch, count down busy cycles, commit HI/LO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_pend    <= '0;
            r_pend_ok <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            unique case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        if (w_is_mul) begin
                            r_state   <= MD_BUSY_MUL;
                            r_cnt     <= MUL_N;
                            r_busy    <= 1'b1;
                            r_pend    <= w_prod;
                            r_pend_ok <= 1'b1;
                        end else if (w_is_div) begin
                            r_state   <= MD_BUSY_DIV;
                            r_cnt     <= DIV_N;
                            r_busy    <= 1'b1;
                            r_pend    <= {w_r, w_q};
                            r_pend_ok <= ~w_div_zero;
                        end else if (md_op == MD_MTHI) begin
                            r_hi <= In0;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= In0;
                        end
                    end
                end
                MD_BUSY_MUL, MD_BUSY_DIV: begin
                    if (r_cnt == ONE) begin
                        r_state <= MD_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        if (r_pend_ok) begin
                            r_hi <= r_pend.hi;
                            r_lo <= r_pend.lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - ONE;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Same-cycle read of the committed HI/LO.
    always_comb begin
        Res = 32'd0;
        case (md_op)
            MD_MFHI: Res = r_hi;
            MD_MFLO: Res = r_lo;
            default: Res = 32'd0;
        endcase
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus random
// operations against a 64-bit arithmetic reference model.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] In0 = 32'd0;
    logic [31:0] In1 = 32'd0;
    logic        busy;
    logic [31:0] Res;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .In0     (In0),
        .In1     (In1),
        .busy    (busy),
        .Res     (Res),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic model_apply(input logic [3:0] op,
                               input logic [31:0] a,
                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0] t;
        logic [63:0] t2;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT: begin
                t = sa * sb;
                m_hi = t[63:32];
                m_lo = t[31:0];
            end
            MD_MULTU: begin
                t = ua * ub;
                m_hi = t[63:32];
                m_lo = t[31:0];
            end
            MD_DIV: if (b != 0) begin
                t  = sa / sb;
                t2 = sa % sb;
                m_lo = t[31:0];
                m_hi = t2[31:0];
            end
            MD_DIVU: if (b != 0) begin
                t  = ua / ub;
                t2 = ua % ub;
                m_lo = t[31:0];
                m_hi = t2[31:0];
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        int exp_n;
        exp_n = (op == MD_MULT || op == MD_MULTU) ? NM :
                (op == MD_DIV || op == MD_DIVU) ? ND : 0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_while_busy busy=%b required=0", busy);
        end
        start = 1'b1;
        md_op = op;
        In0 = a;
        In1 = b;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        In0 = $urandom;
        In1 = $urandom;
        n = 0;
        while (busy === 1'b1 && n < ND + 20) begin
            if (n == 0) begin
                md_op = MD_MFLO;
                #1;
                n_cmp++;
                if (Res !== m_lo) begin
                    n_bad++;
                    $display("FAIL mflo_during_busy got=%h required=%h",
                             Res, m_lo);
                end
                n_cmp++;
                if (hi !== m_hi) begin
                    n_bad++;
                    $display("FAIL hi_during_busy got=%h required=%h",
                             hi, m_hi);
                end
                md_op = MD_NONE;
            end
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n != exp_n) begin
            n_bad++;
            $display("FAIL busy_cycles op=%0d got=%0d required=%0d",
                     op, n, exp_n);
        end
        model_apply(op, a, b);
        n_cmp++;
        if (hi !== m_hi) begin
            n_bad++;
            $display("FAIL hi op=%0d a=%h b=%h got=%h required=%h",
                     op, a, b, hi, m_hi);
        end
        n_cmp++;
        if (lo !== m_lo) begin
            n_bad++;
            $display("FAIL lo op=%0d a=%h b=%h got=%h required=%h",
                     op, a, b, lo, m_lo);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state busy=%b hi=%h lo=%h required 0/0/0",
                     busy, hi, lo);
        end
        n_cmp++;
        if (Res !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_res got=%h required=0", Res);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_mult();
        run_op(MD_MULT, 32'hFFFFFFFE, 32'h00000003);
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            n_bad++;
            $display("FAIL mult_const got=%h_%h required=ffffffff_fffffffa",
                     hi, lo);
        end
    endtask

    task automatic test_multu();
        run_op(MD_MULTU, 32'hFFFFFFFE, 32'h00000003);
        n_cmp++;
        if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            n_bad++;
            $display("FAIL multu_const got=%h_%h required=00000002_fffffffa",
                     hi, lo);
        end
    endtask

    task automatic test_div();
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_bad++;
            $display("FAIL div_const got=%h_%h required=ffffffff_fffffffd",
                     hi, lo);
        end
    endtask

    task automatic test_div_overflow();
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        n_cmp++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            n_bad++;
            $display("FAIL div_ovf got=%h_%h required=00000000_80000000",
                     hi, lo);
        end
    endtask

    task automatic test_divu_zero();
        run_op(MD_MTHI, 32'h11, 32'd0);
        run_op(MD_MTLO, 32'h22, 32'd0);
        run_op(MD_DIVU, 32'd7, 32'd0);
        n_cmp++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            n_bad++;
            $display("FAIL divu_zero got=%h_%h required=00000011_00000022",
                     hi, lo);
        end
    endtask

    task automatic test_mthi_mfhi();
        run_op(MD_MTHI, 32'h1234, 32'd0);
        md_op = MD_MFHI;
        #1;
        n_cmp++;
        if (Res !== 32'h1234 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mfhi got=%h busy=%b required=00001234 busy=0",
                     Res, busy);
        end
        md_op = MD_MULT;
        #1;
        n_cmp++;
        if (Res !== 32'd0) begin
            n_bad++;
            $display("FAIL res_other_op got=%h required=0", Res);
        end
        md_op = MD_NONE;
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk);
        start = 1'b1;
        md_op = MD_DIV;
        In0 = 32'd1000;
        In1 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_div busy=%b hi=%h lo=%h required 0/0/0",
                     busy, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (ND) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_bad++;
            $display("FAIL aborted_no_commit busy=%b hi=%h lo=%h required 0",
                     busy, hi, lo);
        end
    endtask

    task automatic test_after_reset();
        run_op(MD_MULT, 32'd123456, 32'hFFFFFF00);
    endtask

    task automatic test_random();
        logic [3:0] ops [6];
        logic [3:0] op;
        logic [31:0] a;
        logic [31:0] b;
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(op, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_overflow();
        test_divu_zero();
        test_mthi_mfhi();
        test_reset_mid_div();
        test_after_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
